// File: rtl/mem_arbiter.sv
//==============================================================================
// Module   : mem_arbiter
// Purpose  : Shares the single main-memory port between the I-cache and D-cache
//            miss paths. Build macro ARB_ROUND_ROBIN_EN selects round-robin
//            arbitration instead of fixed D-over-I priority.
// Revision : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        grant
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [1:0] c_GRANT_NONE = 2'b00;
    localparam logic [1:0] c_GRANT_I    = 2'b01;
    localparam logic [1:0] c_GRANT_D    = 2'b10;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_d_req;
    logic              w_pick_d;
    logic              w_pick_i;
    logic              w_done;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_i_ready;
    logic              r_d_ready;
    logic [1:0]        r_grant;

    assign w_d_req  = d_read | d_write;
    assign w_done   = ((r_state == BUSY_I) || (r_state == BUSY_D)) && mem_ready;
    assign w_pick_i = i_read & ~w_pick_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_d;  // 1 when the D side owned the most recent completed transfer

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_d <= 1'b0;
        end else if (w_done) begin
            r_last_d <= (r_state == BUSY_D);
        end
    end

    assign w_pick_d = w_d_req & (~i_read | ~r_last_d);
`else
    assign w_pick_d = w_d_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_pick_d) begin
                    w_state_nxt = BUSY_D;
                end else if (w_pick_i) begin
                    w_state_nxt = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready) begin
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_i_ready   <= 1'b0;
            r_d_ready   <= 1'b0;
            r_grant     <= c_GRANT_NONE;
        end else begin
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A simultaneous read and write-back is issued as the write-back
                    if (w_pick_d) begin
                        r_mem_read  <= ~d_write;
                        r_mem_write <= d_write;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                        r_grant     <= c_GRANT_D;
                    end else if (w_pick_i) begin
                        r_mem_read  <= 1'b1;
                        r_mem_write <= 1'b0;
                        r_mem_addr  <= i_addr;
                        r_grant     <= c_GRANT_I;
                    end
                end
                BUSY_I: begin
                    if (mem_ready) begin
                        r_mem_read <= 1'b0;
                        r_i_rdata  <= mem_rdata;
                        r_i_ready  <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (mem_ready) begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_d_ready   <= 1'b1;
                        if (r_mem_read) begin
                            r_d_rdata <= mem_rdata;
                        end
                    end
                end
                RESP:    r_grant <= c_GRANT_NONE;
                default: r_grant <= c_GRANT_NONE;
            endcase
        end
    end

    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign i_ready   = r_i_ready;
    assign d_ready   = r_d_ready;
    assign grant     = r_grant;

endmodule

`default_nettype wire
